da_mode_scheduler: RTL and testbench

- Sequences the DA output path.
- Debounces a step button, cycles the output mode 0..7 across the eight filter sources (raw/filtered for direct FIR, polyphase, decimator, interpolator), and switches sources through a mute interval so the DAC never sees a truncated clock pulse or a mixed sample.
- In normal running it registers the selected source's samples and generates a DA_clk pulse per sample.

---
 rtl/da_mode_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_da_mode_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_mode_scheduler.sv
// DA output sequencer: debounced mode stepping with drain/mute source switching.
// Optional AUTO_SCAN_EN adds a periodic step event alongside the button.
module da_mode_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MUTE_CYCLES     = 1024,
  parameter int SETUP_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int SCAN_PERIOD     = 50000000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        key_n,
  input  logic [7:0]  src_valid,
  input  logic [63:0] src_data,
  output logic [13:0] DA_value,
  output logic        DA_clk,
  output logic [2:0]  mode,
  output logic        switching,
  output logic        stall
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MW = $clog2(MUTE_CYCLES + 1);
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [MW-1:0] MUTE_LAST  = MW'(MUTE_CYCLES - 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES);
  localparam logic [13:0]   MID        = 14'h2000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    MUTE  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic          key_s1, key_s2;
  logic          key_last, key_acc;
  logic [DW-1:0] db_cnt;
  logic          key_evt;
  logic          step;

  assign key_evt = (key_s2 == key_last) && (db_cnt == DB_LAST)
                   && !key_last && key_acc;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_last <= 1'b1;
      key_acc  <= 1'b1;
      db_cnt   <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      if (key_s2 != key_last) begin
        key_last <= key_s2;
        db_cnt   <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_acc <= key_last;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

`ifdef AUTO_SCAN_EN
  localparam int CW = $clog2(SCAN_PERIOD + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_PERIOD - 1);

  logic [CW-1:0] scan_cnt;
  logic          scan_evt;

  assign scan_evt = (scan_cnt == SCAN_LAST);
  assign step     = key_evt | scan_evt;

  // Manual steps restart the interval so the next auto step is a full period away.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      scan_cnt <= '0;
    else if (step)
      scan_cnt <= '0;
    else
      scan_cnt <= scan_cnt + CW'(1);
  end
`else
  assign step = key_evt;
`endif

  logic [13:0]   val_nx;
  logic          clk_nx;
  logic [2:0]    mode_nx, pending, pend_nx;
  logic [SW-1:0] setup_cnt, setup_nx;
  logic [MW-1:0] mute_cnt, mute_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          stall_nx;
  logic          sel_valid;
  logic [7:0]    sel_data, sel_code;

  assign sel_valid = src_valid[mode];
  assign sel_data  = src_data[{mode, 3'b000} +: 8];
  assign sel_code  = sel_data + 8'd128;
  assign switching = (state != RUN);

  always_comb begin
    state_nx = state;
    val_nx   = DA_value;
    clk_nx   = DA_clk;
    setup_nx = setup_cnt;
    mute_nx  = mute_cnt;
    tcnt_nx  = tcnt;
    stall_nx = stall;
    mode_nx  = mode;
    pend_nx  = pending;
    // A low DA_clk always runs to its full setup time, whatever the state.
    if (!DA_clk) begin
      if (setup_cnt == SETUP_LAST)
        clk_nx = 1'b1;
      else
        setup_nx = setup_cnt + SW'(1);
    end
    case (state)
      RUN: begin
        if (sel_valid) begin
          val_nx   = {sel_code, 6'b0};
          clk_nx   = 1'b0;
          setup_nx = '0;
          tcnt_nx  = '0;
          stall_nx = 1'b0;
        end else if (tcnt != TO_MAX) begin
          tcnt_nx = tcnt + TW'(1);
          if (tcnt == TO_LAST)
            stall_nx = 1'b1;
        end
        if (step) begin
          state_nx = DRAIN;
          pend_nx  = mode + 3'd1;
        end
      end
      DRAIN: begin
        tcnt_nx = '0;
        if (DA_clk) begin
          state_nx = MUTE;
          val_nx   = MID;
          clk_nx   = 1'b0;
          setup_nx = '0;
          mute_nx  = '0;
        end
      end
      MUTE: begin
        tcnt_nx = '0;
        if (mute_cnt == MUTE_LAST) begin
          state_nx = RUN;
          mode_nx  = pending;
          stall_nx = 1'b0;
        end else begin
          mute_nx = mute_cnt + MW'(1);
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      DA_value  <= MID;
      DA_clk    <= 1'b1;
      setup_cnt <= '0;
      mute_cnt  <= '0;
      tcnt      <= '0;
      stall     <= 1'b0;
      mode      <= 3'd0;
      pending   <= 3'd0;
    end else begin
      state     <= state_nx;
      DA_value  <= val_nx;
      DA_clk    <= clk_nx;
      setup_cnt <= setup_nx;
      mute_cnt  <= mute_nx;
      tcnt      <= tcnt_nx;
      stall     <= stall_nx;
      mode      <= mode_nx;
      pending   <= pend_nx;
    end
  end

endmodule

// File: tb/tb_da_mode_scheduler.sv
// Bench for da_mode_scheduler: event-level model compared every cycle,
// plus directed literal checks on pulse widths, codes, stall and reset.
module tb_da_mode_scheduler;

  localparam int DEB   = 16;
  localparam int MUTEC = 1024;
  localparam int SETUP = 4;
  localparam int TOUT  = 64;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        key_n = 1'b1;
  logic [7:0]  src_valid = '0;
  logic [63:0] src_data = '0;
  logic [13:0] DA_value;
  logic        DA_clk;
  logic [2:0]  mode;
  logic        switching;
  logic        stall;

  int compared = 0;
  int mismatched = 0;

  da_mode_scheduler #(
    .DEBOUNCE_CYCLES(DEB),
    .MUTE_CYCLES(MUTEC),
    .SETUP_CYCLES(SETUP),
    .TIMEOUT_CYCLES(TOUT),
    .SCAN_PERIOD(200)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .key_n(key_n),
    .src_valid(src_valid),
    .src_data(src_data),
    .DA_value(DA_value),
    .DA_clk(DA_clk),
    .mode(mode),
    .switching(switching),
    .stall(stall)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [13:0] dac_code(input logic [7:0] s);
    logic [7:0] u;
    u = s ^ 8'h80;
    return {u, 6'b0};
  endfunction

  // Model: phase 0 run, 1 drain, 2 mute; m_low = DA_clk low cycles still due.
  int          m_mode = 0, m_pend = 0, m_phase = 0;
  int          m_low = 0, m_mute = 0, m_idle = 0, m_lowrun = 0;
  logic [13:0] m_val = 14'h2000;
  logic        m_stall = 1'b0;
  logic [1:0]  kh = 2'b11;
  logic        m_delayed, m_press, m_was_high;

  initial forever begin
    @(posedge clk_in or posedge rst);
    if (rst) begin
      m_mode = 0; m_pend = 0; m_phase = 0; m_low = 0; m_mute = 0;
      m_idle = 0; m_lowrun = 0; m_val = 14'h2000; m_stall = 1'b0;
      kh = 2'b11;
    end else begin
      m_delayed = kh[1];
      kh = {kh[0], key_n};
      m_lowrun = m_delayed ? 0 : m_lowrun + 1;
      m_press = (m_lowrun == DEB + 1);
      m_was_high = (m_low == 0);
      if (m_low > 0) m_low = m_low - 1;
      if (m_phase == 0) begin
        if (src_valid[m_mode]) begin
          m_val = dac_code(src_data[m_mode*8 +: 8]);
          m_low = SETUP;
          m_idle = 0;
          m_stall = 1'b0;
        end else begin
          if (m_idle < 1000000) m_idle = m_idle + 1;
          if (m_idle >= TOUT) m_stall = 1'b1;
        end
        if (m_press) begin
          m_phase = 1;
          m_pend = (m_mode + 1) % 8;
        end
      end else if (m_phase == 1) begin
        m_idle = 0;
        if (m_was_high) begin
          m_phase = 2;
          m_val = 14'h2000;
          m_low = SETUP;
          m_mute = MUTEC;
        end
      end else begin
        m_idle = 0;
        m_mute = m_mute - 1;
        if (m_mute == 0) begin
          m_mode = m_pend;
          m_phase = 0;
          m_stall = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (!rst) begin
      compared++;
      if (DA_value !== m_val || DA_clk !== (m_low == 0) || mode !== 3'(m_mode)
          || switching !== (m_phase != 0) || stall !== m_stall) begin
        mismatched++;
        $display("FAIL cycle t=%0t dut val=%h clk=%b mode=%0d sw=%b stall=%b want val=%h clk=%b mode=%0d sw=%b stall=%b",
                 $time, DA_value, DA_clk, mode, switching, stall,
                 m_val, (m_low == 0), m_mode, (m_phase != 0), m_stall);
      end
    end
  end

  int low_run = 0, last_low = 0, pulses = 0;

  initial forever begin
    @(negedge clk_in);
    if (rst) begin
      low_run = 0;
    end else if (!DA_clk) begin
      low_run++;
    end else if (low_run > 0) begin
      last_low = low_run;
      low_run = 0;
      pulses++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic strobe(input int src, input logic [7:0] d);
    src_data[src*8 +: 8] = d;
    src_valid = '0;
    src_valid[src] = 1'b1;
    step(1);
    src_valid = '0;
  endtask

  task automatic press();
    key_n = 1'b0;
    step(20);
    key_n = 1'b1;
    step(1100);
  endtask

  int p0;

  initial begin
    step(3);
    chk("reset_val", 32'(DA_value), 32'h2000);
    chk("reset_clk", 32'(DA_clk), 32'd1);
    chk("reset_mode", 32'(mode), 32'd0);
    chk("reset_sw", 32'(switching), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    step(2);

    for (int i = 0; i < 3; i++) begin
      strobe(0, 8'h00);
      chk("zero_code", 32'(DA_value), 32'h2000);
      step(5);
      chk("zero_pulse_len", 32'(last_low), 32'd4);
      step(94);
    end
    chk("mode_after_zero", 32'(mode), 32'd0);

    strobe(0, 8'h7F);
    chk("code_7f", 32'(DA_value), 32'h3FC0);
    step(5);
    strobe(0, 8'h80);
    chk("code_80", 32'(DA_value), 32'h0000);
    step(5);
    p0 = pulses;
    strobe(3, 8'h55);
    step(10);
    chk("other_src_pulses", 32'(pulses - p0), 32'd0);
    chk("other_src_val", 32'(DA_value), 32'h0000);

    strobe(0, 8'h01);
    step(1);
    strobe(0, 8'h02);
    step(8);
    chk("supersede_len", 32'(last_low), 32'd6);
    chk("supersede_val", 32'(DA_value), 32'h2080);

    key_n = 1'b0;
    step(10);
    key_n = 1'b1;
    step(60);
    chk("short_press_mode", 32'(mode), 32'd0);
    chk("short_press_sw", 32'(switching), 32'd0);

    key_n = 1'b0;
    step(20);
    key_n = 1'b1;
    chk("mute_sw", 32'(switching), 32'd1);
    chk("mute_val", 32'(DA_value), 32'h2000);
    chk("mute_clk_low", 32'(DA_clk), 32'd0);
    step(1100);
    chk("mute_pulse_len", 32'(last_low), 32'd4);
    chk("mode_one", 32'(mode), 32'd1);
    chk("sw_done", 32'(switching), 32'd0);

    key_n = 1'b0;
    step(16);
    strobe(1, 8'h40);
    step(4);
    key_n = 1'b1;
    chk("drain_pulse_len", 32'(last_low), 32'd4);
    chk("drain_clk_high", 32'(DA_clk), 32'd1);
    chk("drain_val", 32'(DA_value), 32'h3000);
    chk("drain_sw", 32'(switching), 32'd1);
    step(1);
    chk("drain_to_mute", 32'(DA_value), 32'h2000);
    step(1100);
    chk("mode_two", 32'(mode), 32'd2);

    for (int i = 0; i < 6; i++) press();
    chk("mode_wrap", 32'(mode), 32'd0);

    strobe(0, 8'h11);
    step(63);
    chk("stall_before", 32'(stall), 32'd0);
    step(1);
    chk("stall_at_64", 32'(stall), 32'd1);
    strobe(0, 8'h12);
    chk("stall_cleared", 32'(stall), 32'd0);
    step(10);

    press();
    chk("mode_before_rst", 32'(mode), 32'd1);
    key_n = 1'b0;
    step(20);
    key_n = 1'b1;
    step(2);
    rst = 1'b1;
    #1;
    chk("rst_val", 32'(DA_value), 32'h2000);
    chk("rst_clk", 32'(DA_clk), 32'd1);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_sw", 32'(switching), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    step(3);
    rst = 1'b0;
    step(50);
    chk("after_rst_mode", 32'(mode), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
